// File: rtl/sample_playback_counter_if.sv
// Bus between the note controller / sample memory side and the playback datapath.
// The master side drives the note parameters, the step/count pulses and the
// memory read data; the slave side (the datapath) returns the read address,
// the latched sample with its strobe, and the note status.
interface sample_playback_counter_if #(
  parameter int ADDR_W = 16,
  parameter int STEP_W = 12,
  parameter int CNT_W  = 16,
  parameter int DATA_W = 16
);
  logic              load;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] loop_start;
  logic [ADDR_W-1:0] loop_end;
  logic              loop_en;
  logic [STEP_W-1:0] step;
  logic [CNT_W-1:0]  note_len;
  logic              increment;
  logic              count_inc;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] sample_out;
  logic              sample_valid;
  logic              count_done;
  logic              active;

  modport master (
    output load, start_addr, loop_start, loop_end, loop_en, step, note_len,
    output increment, count_inc, mem_data,
    input  mem_addr, sample_out, sample_valid, count_done, active
  );

  modport slave (
    input  load, start_addr, loop_start, loop_end, loop_en, step, note_len,
    input  increment, count_inc, mem_data,
    output mem_addr, sample_out, sample_valid, count_done, active
  );
endinterface

// File: rtl/sample_playback_counter.sv
// Note-playback datapath: fixed-point phase accumulator walking sample memory
// with loop-region wrapping, a note-length sample counter, and a three-stage
// read pipeline that presents each fetched sample with a one-cycle strobe.
module sample_playback_counter #(
  parameter int ADDR_W = 16,
  parameter int FRAC_W = 8,
  parameter int STEP_W = 12,
  parameter int CNT_W  = 16,
  parameter int DATA_W = 16
) (
  input logic                      Clk,
  input logic                      Reset,
  sample_playback_counter_if.slave bus
);
  localparam int PH_W = ADDR_W + FRAC_W;

  // latched note parameters
  logic [ADDR_W-1:0] loop_start_r;
  logic [ADDR_W-1:0] loop_end_r;
  logic              loop_en_r;
  logic [STEP_W-1:0] step_r;
  logic [CNT_W-1:0]  note_len_r;

  // note state
  logic [PH_W-1:0]   phase_r;
  logic [CNT_W-1:0]  count_r;
  logic              count_done_r;
  logic              active_r;

  // read pipeline: rd_p1_r = new address presented, rd_p2_r = memory data valid
  logic              rd_p1_r;
  logic              rd_p2_r;
  logic              sample_valid_r;
  logic [DATA_W-1:0] sample_out_r;

  // next-state helpers
  logic              inc_go_s;
  logic              cnt_go_s;
  logic [PH_W:0]     nxt_s;
  logic [ADDR_W:0]   nxt_int_s;
  logic [ADDR_W:0]   loop_len_s;
  logic [ADDR_W:0]   wrap_int_s;
  logic [PH_W-1:0]   step_phase_s;
  logic [CNT_W-1:0]  cnt_sat_s;

  // load wins over both pulses; pulses only act while a note is in progress
  assign inc_go_s = bus.increment & active_r & ~bus.load;
  assign cnt_go_s = bus.count_inc & active_r & ~bus.load;

  // phase step with carry bit and loop-region wrap selection
  always_comb begin
    nxt_s        = {1'b0, phase_r} + {{(PH_W + 1 - STEP_W){1'b0}}, step_r};
    nxt_int_s    = nxt_s[PH_W:FRAC_W];
    loop_len_s   = {1'b0, loop_end_r} - {1'b0, loop_start_r} + {{ADDR_W{1'b0}}, 1'b1};
    wrap_int_s   = nxt_int_s - loop_len_s;
    step_phase_s = nxt_s[PH_W-1:0];
    if (nxt_int_s <= {1'b0, loop_end_r}) begin
      step_phase_s = nxt_s[PH_W-1:0];
    end else if (loop_en_r && (wrap_int_s <= {1'b0, loop_end_r})) begin
      // one wrap is enough: fraction carries over unchanged
      step_phase_s = {wrap_int_s[ADDR_W-1:0], nxt_s[FRAC_W-1:0]};
    end else if (loop_en_r) begin
      // step overshoots a whole loop length: restart at loop_start
      step_phase_s = {loop_start_r, nxt_s[FRAC_W-1:0]};
    end else begin
      // one-shot note parks on the last sample
      step_phase_s = {loop_end_r, {FRAC_W{1'b0}}};
    end
  end

  // saturating sample-count increment
  always_comb begin
    if (count_r == {CNT_W{1'b1}}) begin
      cnt_sat_s = count_r;
    end else begin
      cnt_sat_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // note parameter latch
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      loop_start_r <= {ADDR_W{1'b0}};
      loop_end_r   <= {ADDR_W{1'b0}};
      loop_en_r    <= 1'b0;
      step_r       <= {STEP_W{1'b0}};
      note_len_r   <= {CNT_W{1'b0}};
    end else if (bus.load) begin
      loop_start_r <= bus.loop_start;
      loop_end_r   <= bus.loop_end;
      loop_en_r    <= bus.loop_en;
      step_r       <= bus.step;
      note_len_r   <= bus.note_len;
    end
  end

  // phase accumulator
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      phase_r <= {PH_W{1'b0}};
    end else if (bus.load) begin
      phase_r <= {bus.start_addr, {FRAC_W{1'b0}}};
    end else if (inc_go_s) begin
      phase_r <= step_phase_s;
    end
  end

  // sample counter, done flag and note-active flag
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      count_r      <= {CNT_W{1'b0}};
      count_done_r <= 1'b0;
      active_r     <= 1'b0;
    end else if (bus.load) begin
      // a zero-length note is already complete at the load edge
      count_r      <= {CNT_W{1'b0}};
      count_done_r <= (bus.note_len == {CNT_W{1'b0}});
      active_r     <= (bus.note_len != {CNT_W{1'b0}});
    end else if (cnt_go_s) begin
      count_r <= cnt_sat_s;
      if (cnt_sat_s >= note_len_r) begin
        count_done_r <= 1'b1;
        active_r     <= 1'b0;
      end
    end
  end

  // read pipeline: address -> memory data -> latched sample with strobe
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rd_p1_r        <= 1'b0;
      rd_p2_r        <= 1'b0;
      sample_valid_r <= 1'b0;
      sample_out_r   <= {DATA_W{1'b0}};
    end else if (bus.load) begin
      rd_p1_r        <= 1'b0;
      rd_p2_r        <= 1'b0;
      sample_valid_r <= 1'b0;
    end else begin
      rd_p1_r        <= inc_go_s;
      rd_p2_r        <= rd_p1_r;
      sample_valid_r <= rd_p2_r;
      if (rd_p2_r) begin
        sample_out_r <= bus.mem_data;
      end
    end
  end

  assign bus.mem_addr     = phase_r[PH_W-1:FRAC_W];
  assign bus.sample_out   = sample_out_r;
  assign bus.sample_valid = sample_valid_r;
  assign bus.count_done   = count_done_r;
  assign bus.active       = active_r;
endmodule

// File: tb/tb_sample_playback_counter.sv
// Directed bench for sample_playback_counter with a synchronous sample ROM model.
module tb_sample_playback_counter;
  logic Clk;
  logic Reset;
  int   total;
  int   bad;

  sample_playback_counter_if #(.ADDR_W(16), .STEP_W(12), .CNT_W(16), .DATA_W(16)) bus ();

  sample_playback_counter #(
    .ADDR_W(16), .FRAC_W(8), .STEP_W(12), .CNT_W(16), .DATA_W(16)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [15:0] rom(input logic [15:0] a);
    return a ^ 16'hA5C3;
  endfunction

  // synchronous sample ROM: data one cycle after address
  always_ff @(posedge Clk) bus.mem_data <= rom(bus.mem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] sa, input logic [15:0] ls, input logic [15:0] le,
                         input logic en, input logic [11:0] st, input logic [15:0] nl);
    bus.load = 1'b1; bus.start_addr = sa; bus.loop_start = ls; bus.loop_end = le;
    bus.loop_en = en; bus.step = st; bus.note_len = nl;
    tick();
    bus.load = 1'b0;
  endtask

  // single increment, then follow its sample through the read pipeline
  task automatic inc_and_follow(input string tag, input logic [15:0] exp_addr);
    bus.increment = 1'b1;
    tick();
    bus.increment = 1'b0;
    chk({tag, "_addr"}, 32'(bus.mem_addr), 32'(exp_addr));
    tick();
    chk({tag, "_v_early"}, 32'(bus.sample_valid), 32'd0);
    tick();
    chk({tag, "_v"}, 32'(bus.sample_valid), 32'd1);
    chk({tag, "_data"}, 32'(bus.sample_out), 32'(rom(exp_addr)));
    tick();
    chk({tag, "_v_late"}, 32'(bus.sample_valid), 32'd0);
  endtask

  // independent phase-step reference
  function automatic logic [23:0] ref_next(input logic [23:0] ph, input logic [11:0] st,
                                           input logic [15:0] ls, input logic [15:0] le,
                                           input logic en);
    int unsigned nx;
    int unsigned ni;
    int unsigned len;
    nx  = int'(ph) + int'(st);
    ni  = nx >> 8;
    len = int'(le) - int'(ls) + 1;
    if (ni <= int'(le)) return nx[23:0];
    else if (!en) return {le, 8'h00};
    else if (ni - int'(le) <= len) return 24'(nx - (len << 8));
    else return {ls, nx[7:0]};
  endfunction

  initial begin
    logic [23:0] ph;
    logic [11:0] st;
    total = 0; bad = 0;
    Reset = 1'b0;
    bus.load = 1'b0; bus.start_addr = 16'h0; bus.loop_start = 16'h0; bus.loop_end = 16'h0;
    bus.loop_en = 1'b0; bus.step = 12'h0; bus.note_len = 16'h0;
    bus.increment = 1'b0; bus.count_inc = 1'b0;
    tick(); tick();
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_active", 32'(bus.active), 32'd0);
    chk("rst_done", 32'(bus.count_done), 32'd0);
    chk("rst_valid", 32'(bus.sample_valid), 32'd0);
    Reset = 1'b1;
    tick();

    // mid-note async reset: phase 0x0123_40 with a sample already latched
    do_load(16'h0123, 16'h0000, 16'hFFFF, 1'b0, 12'h040, 16'd100);
    inc_and_follow("pre_rst", 16'h0123);
    #2 Reset = 1'b0;
    #1;
    chk("arst_addr", 32'(bus.mem_addr), 32'd0);
    chk("arst_active", 32'(bus.active), 32'd0);
    chk("arst_sample", 32'(bus.sample_out), 32'd0);
    chk("arst_valid", 32'(bus.sample_valid), 32'd0);
    tick();
    Reset = 1'b1;
    bus.increment = 1'b1; bus.count_inc = 1'b1;
    tick(); tick();
    bus.increment = 1'b0; bus.count_inc = 1'b0;
    chk("post_rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("post_rst_active", 32'(bus.active), 32'd0);
    chk("post_rst_done", 32'(bus.count_done), 32'd0);

    // step 1.5, no loop
    do_load(16'h0100, 16'h0000, 16'hFFFF, 1'b0, 12'h180, 16'd100);
    chk("ld_addr", 32'(bus.mem_addr), 32'h0100);
    chk("ld_active", 32'(bus.active), 32'd1);
    inc_and_follow("s15_1", 16'h0101);
    inc_and_follow("s15_2", 16'h0103);
    inc_and_follow("s15_3", 16'h0104);
    inc_and_follow("s15_4", 16'h0106);

    // loop wrap with back-to-back increments and back-to-back strobes
    do_load(16'h0012, 16'h0010, 16'h0013, 1'b1, 12'h200, 16'd100);
    chk("lp_start", 32'(bus.mem_addr), 32'h0012);
    bus.increment = 1'b1;
    tick(); chk("lp_a1", 32'(bus.mem_addr), 32'h0010);
    tick(); chk("lp_a2", 32'(bus.mem_addr), 32'h0012);
    tick(); bus.increment = 1'b0;
    chk("lp_a3", 32'(bus.mem_addr), 32'h0010);
    chk("lp_v1", 32'(bus.sample_valid), 32'd1);
    chk("lp_d1", 32'(bus.sample_out), 32'(rom(16'h0010)));
    tick();
    chk("lp_v2", 32'(bus.sample_valid), 32'd1);
    chk("lp_d2", 32'(bus.sample_out), 32'(rom(16'h0012)));
    tick();
    chk("lp_v3", 32'(bus.sample_valid), 32'd1);
    chk("lp_d3", 32'(bus.sample_out), 32'(rom(16'h0010)));
    tick();
    chk("lp_v_end", 32'(bus.sample_valid), 32'd0);
    chk("lp_hold", 32'(bus.sample_out), 32'(rom(16'h0010)));

    // same loop, one-shot: park on loop_end
    do_load(16'h0012, 16'h0010, 16'h0013, 1'b0, 12'h200, 16'd100);
    bus.increment = 1'b1;
    tick(); chk("nl_a1", 32'(bus.mem_addr), 32'h0013);
    tick(); chk("nl_a2", 32'(bus.mem_addr), 32'h0013);
    bus.increment = 1'b0;

    // note length 3
    do_load(16'h0050, 16'h0000, 16'hFFFF, 1'b0, 12'h100, 16'd3);
    for (int i = 0; i < 3; i++) begin
      bus.count_inc = 1'b1;
      tick();
      bus.count_inc = 1'b0;
      chk("cnt_done", 32'(bus.count_done), (i == 2) ? 32'd1 : 32'd0);
      chk("cnt_active", 32'(bus.active), (i == 2) ? 32'd0 : 32'd1);
    end
    bus.increment = 1'b1;
    tick();
    bus.increment = 1'b0;
    chk("idle_addr", 32'(bus.mem_addr), 32'h0050);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_valid", 32'(bus.sample_valid), 32'd0);
    end
    chk("done_hold", 32'(bus.count_done), 32'd1);

    // load and increment together: increment dropped, fraction cleared
    do_load(16'h0300, 16'h0000, 16'hFFFF, 1'b0, 12'h180, 16'd100);
    bus.increment = 1'b1;
    tick();
    bus.increment = 1'b0;
    bus.load = 1'b1; bus.start_addr = 16'h0200; bus.increment = 1'b1;
    tick();
    bus.load = 1'b0; bus.increment = 1'b0;
    chk("li_addr", 32'(bus.mem_addr), 32'h0200);
    chk("li_done", 32'(bus.count_done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("li_valid", 32'(bus.sample_valid), 32'd0);
    end
    inc_and_follow("li_1", 16'h0201);
    inc_and_follow("li_2", 16'h0203);

    // zero-length note
    do_load(16'h0400, 16'h0000, 16'hFFFF, 1'b0, 12'h100, 16'd0);
    chk("z_done", 32'(bus.count_done), 32'd1);
    chk("z_active", 32'(bus.active), 32'd0);

    // overshoot with L=2: fixed 5.0 step, then a random step
    for (int pass = 0; pass < 2; pass++) begin
      st = (pass == 0) ? 12'h500 : 12'($urandom_range(12'h2FF, 12'hFFF));
      do_load(16'h0020, 16'h0020, 16'h0021, 1'b1, st, 16'd1000);
      ph = 24'h002000;
      bus.increment = 1'b1;
      for (int i = 0; i < 20; i++) begin
        tick();
        ph = ref_next(ph, st, 16'h0020, 16'h0021, 1'b1);
        chk("ovs_addr", 32'(bus.mem_addr), 32'(ph[23:8]));
      end
      bus.increment = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
